i2c_xfer_arb: RTL and testbench
===============================

# i2c_xfer_arb

Two-requester transaction arbiter and sequencer for the I2C master path. Sits between two on-chip requesters (e.g. CPU shadow port and DMA) and the master-side control/data signals of the I2C block. Grants one requester at a time round-robin, programs address/direction/count, pulses start, moves data bytes through the TX FIFO / RX buffer, issues stop and returns completion status.

## Interface
- TIMEOUT_CYCLES, 16'd50000, watchdog limit in HCLK cycles with no bus progress (used only with I2C_ARB_TIMEOUT_EN)
- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester transaction request, level, bit g = requester g
- req_addr  in  14  7-bit slave address per requester ([6:0] req 0, [13:7] req 1)
- req_rw  in  2  1 = read, 0 = write, per requester
- req_len  in  16  data byte count per requester ([7:0], [15:8]); 0 = address-only probe
- grant  out  2  one-hot, high from grant until done
- wr_data  in  16  write byte per requester
- wr_valid  in  2  write byte valid
- wr_ready  out  2  write byte accepted when valid & ready
- rd_data  out  8  received byte
- rd_valid  out  2  one-cycle pulse to granted requester
- done  out  2  one-cycle completion pulse
- done_status  out  2  valid with done: 00 ok, 01 nack, 10 timeout
- i2c_adr  out  7 ; i2c_wr  out  1 ; cnt_set  out  8  latched transaction parameters
- i2c_start  out  1 ; i2c_stop  out  1  one-cycle pulses to master
- tx_en  out  1 ; tx_data  out  8  TX FIFO push
- FIFOfull  in  1  TX FIFO full
- sigbyte_finishf  in  1  pulse per completed byte on bus (address byte included)
- i2c_rxbf_set  in  1 ; rx_buf  in  8  received byte strobe/data
- i2c_nackf_set  in  1  NACK detected
- stop_f  in  1  stop condition completed

## Operation
- FSM states: IDLE, GRANT, START, XFER, STOP, WAIT_STOP, DONE.
- IDLE: if any req_valid, pick winner: if both, the one not granted last; else the one valid. Pointer resets to 1 (requester 0 wins first tie).
- GRANT: latch addr/rw/len of winner into i2c_adr/i2c_wr/cnt_set; grant asserted. Request inputs ignored after latch (dropping req_valid has no effect).
- START: i2c_start high one cycle; clear byte counter and address-skip flag.
- XFER: first sigbyte_finishf is the address byte, not counted. Write: wr_ready[g] = ~FIFOfull & pushed < len; push → tx_en=1, tx_data=wr_data[g] same cycle (combinational). Each later sigbyte_finishf increments done count. Read: i2c_rxbf_set → rd_data <= rx_buf, rd_valid[g] pulse next cycle, count++. Exit to STOP when count == len (len 0: after address byte) or on i2c_nackf_set (status nack; remaining writes not pushed).
- STOP: i2c_stop one cycle → WAIT_STOP until stop_f → DONE: done[g] and done_status one cycle, grant drops, pointer = g → IDLE.
- Simultaneous i2c_nackf_set and final sigbyte_finishf: nack wins.
- Counters 8-bit, no wrap (len ≤ 255 by width).

## Timing
- Reset: all outputs 0, state IDLE, pointer 1, regardless of state (mid-transfer abort; bus recovery is the master's job).
- req_valid seen in IDLE at cycle n → grant at n+1, i2c_start at n+2.
- stop_f at cycle m → done at m+1; next grant earliest m+3.
- tx_en never asserted when FIFOfull=1 or outside XFER-write.
- rd_valid latency 1 cycle from i2c_rxbf_set; no backpressure.

## Configuration
- I2C_ARB_TIMEOUT_EN defined: watchdog counter cleared on grant and on every sigbyte_finishf/i2c_rxbf_set/stop_f; reaching TIMEOUT_CYCLES in START/XFER/WAIT_STOP → STOP (or DONE from WAIT_STOP) with status 10.
- Undefined: no counter, FSM waits indefinitely; status 10 never produced.

## Test plan
- Req 0 write addr 0x50 len 2 bytes 0xA5,0x3C → i2c_adr=0x50, i2c_wr=0, cnt_set=2, two tx_en pushes in order, done[0] status 00 after stop_f.
- Req 1 read len 3, rx_buf 0x11,0x22,0x33 → three rd_valid[1] pulses with those values, done[1] status 00.
- Both req_valid from reset → req 0 granted first, req 1 next; repeat → alternation 0,1,0,1.
- NACK on address byte of len 4 write → no further pushes beyond FIFO contents, i2c_stop pulse, done status 01.
- FIFOfull held 10 cycles mid-write → wr_ready low, no tx_en, resumes after release with data intact.
- HRESETn low during XFER → all outputs 0 immediately; with I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100 and no sigbyte_finishf → done status 10.

Source files
------------

// File: rtl/i2c_xfer_arb.sv
// rtl/i2c_xfer_arb.sv - two-requester round-robin arbiter and transaction sequencer for the I2C master
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to enable the TIMEOUT_CYCLES bus-progress timeout.
module i2c_xfer_arb #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  req_valid,
  input  logic [13:0] req_addr,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_len,
  output logic [1:0]  grant,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_valid,
  output logic [1:0]  wr_ready,
  output logic [7:0]  rd_data,
  output logic [1:0]  rd_valid,
  output logic [1:0]  done,
  output logic [1:0]  done_status,
  output logic [6:0]  i2c_adr,
  output logic        i2c_wr,
  output logic [7:0]  cnt_set,
  output logic        i2c_start,
  output logic        i2c_stop,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        FIFOfull,
  input  logic        sigbyte_finishf,
  input  logic        i2c_rxbf_set,
  input  logic [7:0]  rx_buf,
  input  logic        i2c_nackf_set,
  input  logic        stop_f
);

  typedef enum logic [2:0] {IDLE, GRANT, START, XFER, STOP, WAIT_STOP, DONE} state_t;

  state_t      state;
  logic        last;       // requester granted most recently; the other one wins a tie
  logic        sel;        // requester currently owning the bus
  logic [7:0]  pushed;     // bytes handed to the TX FIFO
  logic [7:0]  count;      // data bytes completed on the bus
  logic        addr_seen;  // address byte already finished
  logic [1:0]  status;
  logic        win;
  logic        push_ok;
  logic        addr_evt;
  logic        byte_evt;
  logic [7:0]  cnt_inc;
  logic        finished;
  logic        tmo;

  assign win      = (req_valid == 2'b11) ? ~last : req_valid[1];
  assign addr_evt = sigbyte_finishf & ~addr_seen;
  assign byte_evt = i2c_wr ? i2c_rxbf_set : (sigbyte_finishf & addr_seen);
  assign cnt_inc  = count + 8'd1;
  assign finished = (cnt_set == 8'd0) ? addr_evt : (byte_evt && (cnt_inc == cnt_set));

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] wd;

  // Watchdog counts cycles without bus progress while a transaction is open
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wd <= 16'd0;
    end else if (state == IDLE || state == GRANT || sigbyte_finishf || i2c_rxbf_set || stop_f) begin
      wd <= 16'd0;
    end else if (wd != 16'hFFFF) begin
      wd <= wd + 16'd1;
    end
  end

  assign tmo = (wd >= TIMEOUT_CYCLES);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
`endif

  // Write path: offer bytes to the TX FIFO only while the granted write has room and no NACK
  always_comb begin
    push_ok  = 1'b0;
    wr_ready = 2'b00;
    tx_en    = 1'b0;
    tx_data  = 8'h00;
    if (state == XFER && !i2c_wr && !FIFOfull && !i2c_nackf_set && (pushed < cnt_set)) begin
      push_ok = 1'b1;
    end
    wr_ready = push_ok ? grant : 2'b00;
    tx_en    = push_ok & wr_valid[sel];
    if (tx_en) begin
      tx_data = sel ? wr_data[15:8] : wr_data[7:0];
    end
  end

  // Arbitration and transaction sequencing with registered outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      last        <= 1'b1;
      sel         <= 1'b0;
      grant       <= 2'b00;
      pushed      <= 8'd0;
      count       <= 8'd0;
      addr_seen   <= 1'b0;
      status      <= 2'b00;
      rd_data     <= 8'h00;
      rd_valid    <= 2'b00;
      done        <= 2'b00;
      done_status <= 2'b00;
      i2c_adr     <= 7'd0;
      i2c_wr      <= 1'b0;
      cnt_set     <= 8'd0;
      i2c_start   <= 1'b0;
      i2c_stop    <= 1'b0;
    end else begin
      i2c_start <= 1'b0;
      i2c_stop  <= 1'b0;
      done      <= 2'b00;
      rd_valid  <= 2'b00;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            sel     <= win;
            grant   <= win ? 2'b10 : 2'b01;
            i2c_adr <= win ? req_addr[13:7] : req_addr[6:0];
            i2c_wr  <= req_rw[win];
            cnt_set <= win ? req_len[15:8] : req_len[7:0];
            status  <= 2'b00;
            state   <= GRANT;
          end
        end
        GRANT: begin
          i2c_start <= 1'b1;
          pushed    <= 8'd0;
          count     <= 8'd0;
          addr_seen <= 1'b0;
          state     <= START;
        end
        START: begin
          if (tmo) begin
            status   <= 2'b10;
            i2c_stop <= 1'b1;
            state    <= STOP;
          end else begin
            state <= XFER;
          end
        end
        XFER: begin
          if (tx_en) pushed <= pushed + 8'd1;
          if (addr_evt) addr_seen <= 1'b1;
          if (byte_evt) count <= cnt_inc;
          if (i2c_wr && i2c_rxbf_set) begin
            rd_data  <= rx_buf;
            rd_valid <= grant;
          end
          if (i2c_nackf_set) begin
            status   <= 2'b01;
            i2c_stop <= 1'b1;
            state    <= STOP;
          end else if (finished) begin
            i2c_stop <= 1'b1;
            state    <= STOP;
          end else if (tmo) begin
            status   <= 2'b10;
            i2c_stop <= 1'b1;
            state    <= STOP;
          end
        end
        STOP: begin
          state <= WAIT_STOP;
        end
        WAIT_STOP: begin
          if (stop_f) begin
            done        <= grant;
            done_status <= status;
            state       <= DONE;
          end else if (tmo) begin
            done        <= grant;
            done_status <= 2'b10;
            state       <= DONE;
          end
        end
        DONE: begin
          done_status <= 2'b00;
          grant       <= 2'b00;
          last        <= sel;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_xfer_arb.sv
// tb/tb_i2c_xfer_arb.sv - self-checking bench for i2c_xfer_arb
module tb_i2c_xfer_arb;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  req_valid;
  logic [13:0] req_addr;
  logic [1:0]  req_rw;
  logic [15:0] req_len;
  logic [1:0]  grant;
  logic [15:0] wr_data;
  logic [1:0]  wr_valid;
  logic [1:0]  wr_ready;
  logic [7:0]  rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  done;
  logic [1:0]  done_status;
  logic [6:0]  i2c_adr;
  logic        i2c_wr;
  logic [7:0]  cnt_set;
  logic        i2c_start;
  logic        i2c_stop;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        FIFOfull;
  logic        sigbyte_finishf;
  logic        i2c_rxbf_set;
  logic [7:0]  rx_buf;
  logic        i2c_nackf_set;
  logic        stop_f;

  int n_checks = 0;
  int n_fail   = 0;
  int last_g;
  logic [7:0] wdat [0:7];
  logic [7:0] rdat [0:7];

  typedef struct {
    logic [1:0] mask;
    int         g;
    logic [6:0] a0, a1;
    logic       rw0, rw1;
    int         len0, len1;
    int         nack_at, ff, fl, st;
  } row_t;

  row_t tbl [10];

  i2c_xfer_arb #(.TIMEOUT_CYCLES(16'd100)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_valid(req_valid), .req_addr(req_addr),
    .req_rw(req_rw), .req_len(req_len), .grant(grant), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .done_status(done_status), .i2c_adr(i2c_adr), .i2c_wr(i2c_wr),
    .cnt_set(cnt_set), .i2c_start(i2c_start), .i2c_stop(i2c_stop), .tx_en(tx_en),
    .tx_data(tx_data), .FIFOfull(FIFOfull), .sigbyte_finishf(sigbyte_finishf),
    .i2c_rxbf_set(i2c_rxbf_set), .rx_buf(rx_buf), .i2c_nackf_set(i2c_nackf_set),
    .stop_f(stop_f)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
    sigbyte_finishf = 1'b0;
    i2c_rxbf_set    = 1'b0;
    i2c_nackf_set   = 1'b0;
    stop_f          = 1'b0;
  endtask

  function automatic row_t mk(input logic [1:0] mask, input int g,
                              input logic [6:0] a0, input logic rw0, input int len0,
                              input logic [6:0] a1, input logic rw1, input int len1,
                              input int nack_at, input int ff, input int fl, input int st);
    row_t r;
    r.mask = mask; r.g = g;
    r.a0 = a0; r.rw0 = rw0; r.len0 = len0;
    r.a1 = a1; r.rw1 = rw1; r.len1 = len1;
    r.nack_at = nack_at; r.ff = ff; r.fl = fl; r.st = st;
    return r;
  endfunction

  // Play the master side of one transaction and check everything the arbiter shows
  task automatic do_xfer(input int g, input logic [6:0] adr, input logic rw, input int len,
                         input int nack_at, input int ff, input int fl, input int exp_st);
    int  idx = 0;
    int  k = 0;
    bit  nacked = 0;
    bit  stop_seen = 0;
    logic [1:0] gm;
    gm = (g == 1) ? 2'b10 : 2'b01;
    for (int t = 0; t < 10 && grant == 2'b00; t++) begin
      cyc(); #1;
    end
    chk("grant", grant, gm);
    if (grant == 2'b00) return;
    chk("params", {i2c_adr, i2c_wr, cnt_set}, {adr, rw, len[7:0]});
    req_valid[g] = 1'b0;
    cyc(); #1;
    chk("start_pulse", i2c_start, 1);
    cyc();
    sigbyte_finishf = 1'b1;
    i2c_nackf_set   = (nack_at == 0);
    nacked          = (nack_at == 0);
    #1;
    chk("start_one_cycle", i2c_start, 0);
    while (!rw && !nacked && idx < len && k < 200) begin
      cyc();
      wr_valid = gm;
      wr_data  = (g == 1) ? {wdat[idx], 8'hEE} : {8'hEE, wdat[idx]};
      FIFOfull = (k >= ff && k < ff + fl);
      #1;
      if (FIFOfull) begin
        chk("full_hold", {wr_ready, tx_en}, 0);
      end else begin
        chk("push_ready", {wr_ready, tx_en}, {gm, 1'b1});
        chk("push_data", tx_data, wdat[idx]);
        if (tx_en) begin
          cyc();
          wr_valid = 2'b00;
          FIFOfull = 1'b0;
          idx++;
          sigbyte_finishf = 1'b1;
          i2c_nackf_set   = (nack_at == idx);
          nacked          = (nack_at == idx);
          #1;
        end
      end
      k++;
    end
    if (rw) begin
      for (int i = 0; i < len; i++) begin
        cyc();
        i2c_rxbf_set = 1'b1;
        rx_buf = rdat[i];
        #1;
        cyc(); #1;
        chk("rd_valid", rd_valid, gm);
        chk("rd_data", rd_data, rdat[i]);
        if (i2c_stop) stop_seen = 1;
      end
    end
    wr_valid = rw ? 2'b00 : gm;
    FIFOfull = 1'b0;
    for (int t = 0; t < 20 && !stop_seen; t++) begin
      cyc(); #1;
      if (tx_en) chk("push_after_end", tx_en, 0);
      if (i2c_stop) stop_seen = 1;
    end
    chk("stop_pulse", stop_seen, 1);
    cyc(); #1;
    chk("stop_one_cycle", {i2c_stop, tx_en}, 0);
    cyc();
    stop_f = 1'b1;
    #1;
    chk("no_early_done", done, 0);
    cyc(); #1;
    chk("done", {done, done_status, grant}, {gm, exp_st[1:0], gm});
    cyc(); #1;
    chk("grant_drop", {done, grant}, 0);
    wr_valid = 2'b00;
    if (!rw) chk("push_count", idx, (nack_at >= 0) ? nack_at : len);
  endtask

  task automatic apply_row(input row_t r);
    req_addr  = {r.a1, r.a0};
    req_rw    = {r.rw1, r.rw0};
    req_len   = {r.len1[7:0], r.len0[7:0]};
    req_valid = r.mask;
    if (r.g == 1) do_xfer(1, r.a1, r.rw1, r.len1, r.nack_at, r.ff, r.fl, r.st);
    else          do_xfer(0, r.a0, r.rw0, r.len0, r.nack_at, r.ff, r.fl, r.st);
    req_valid = 2'b00;
  endtask

  initial begin
    HRESETn = 1'b0;
    req_valid = '0; req_addr = '0; req_rw = '0; req_len = '0;
    wr_data = '0; wr_valid = '0; FIFOfull = 0; sigbyte_finishf = 0;
    i2c_rxbf_set = 0; rx_buf = '0; i2c_nackf_set = 0; stop_f = 0;
    for (int i = 0; i < 8; i++) begin
      wdat[i] = 8'($urandom);
      rdat[i] = 8'($urandom);
    end
    wdat[0] = 8'hA5; wdat[1] = 8'h3C;
    rdat[0] = 8'h11; rdat[1] = 8'h22; rdat[2] = 8'h33;

    tbl[0] = mk(2'b01, 0, 7'h50, 0, 2, 7'h33, 1, 1, -1, 99, 0, 0);
    tbl[1] = mk(2'b10, 1, 7'h50, 0, 2, 7'h3B, 1, 3, -1, 99, 0, 0);
    tbl[2] = mk(2'b11, 0, 7'h10, 0, 1, 7'h61, 1, 2, -1, 99, 0, 0);
    tbl[3] = mk(2'b11, 1, 7'h10, 0, 1, 7'h61, 1, 2, -1, 99, 0, 0);
    tbl[4] = mk(2'b11, 0, 7'h10, 0, 1, 7'h61, 1, 2, -1, 99, 0, 0);
    tbl[5] = mk(2'b11, 1, 7'h10, 0, 1, 7'h61, 1, 2, -1, 99, 0, 0);
    tbl[6] = mk(2'b01, 0, 7'h44, 0, 4, 7'h01, 1, 1, 0, 99, 0, 1);
    tbl[7] = mk(2'b10, 1, 7'h02, 1, 1, 7'h7F, 0, 3, -1, 1, 10, 0);
    tbl[8] = mk(2'b01, 0, 7'h12, 1, 0, 7'h03, 0, 1, -1, 99, 0, 0);
    tbl[9] = mk(2'b01, 0, 7'h0F, 0, 3, 7'h04, 0, 1, 2, 99, 0, 1);

    cyc(); cyc(); #1;
    chk("reset_outputs", {grant, wr_ready, rd_data, rd_valid, done, done_status, i2c_adr,
                          i2c_wr, cnt_set, i2c_start, i2c_stop, tx_en, tx_data}, 0);
    HRESETn = 1'b1;
    cyc();

    for (int i = 0; i < 10; i++) apply_row(tbl[i]);

    // Reset while bytes are being pushed: everything must drop at once
    req_addr = {7'h01, 7'h2A}; req_rw = 2'b00; req_len = {8'd1, 8'd2}; req_valid = 2'b01;
    for (int t = 0; t < 10 && grant == 2'b00; t++) begin
      cyc(); #1;
    end
    chk("mid_grant", grant, 2'b01);
    req_valid = 2'b00;
    cyc(); cyc();
    wr_valid = 2'b01; wr_data = 16'hEE77;
    #1;
    chk("mid_push", {tx_en, tx_data}, {1'b1, 8'h77});
    HRESETn = 1'b0;
    #1;
    chk("mid_reset_outputs", {grant, wr_ready, rd_data, rd_valid, done, done_status, i2c_adr,
                              i2c_wr, cnt_set, i2c_start, i2c_stop, tx_en, tx_data}, 0);
    cyc(); cyc();
    HRESETn = 1'b1; wr_valid = 2'b00;
    cyc();

    // Randomized transactions against a round-robin reference model
    last_g = 1;
    for (int n = 0; n < 30; n++) begin
      row_t r;
      int g;
      logic wrw;
      int wlen;
      for (int i = 0; i < 8; i++) begin
        wdat[i] = 8'($urandom);
        rdat[i] = 8'($urandom);
      end
      r.mask = (n == 0) ? 2'b11 : 2'($urandom_range(1, 3));
      g = (r.mask == 2'b11) ? (1 - last_g) : (r.mask[1] ? 1 : 0);
      r.g = g;
      r.a0 = 7'($urandom); r.a1 = 7'($urandom);
      r.rw0 = 1'($urandom); r.rw1 = 1'($urandom);
      r.len0 = $urandom_range(0, 4); r.len1 = $urandom_range(0, 4);
      wrw  = (g == 1) ? r.rw1 : r.rw0;
      wlen = (g == 1) ? r.len1 : r.len0;
      r.nack_at = (!wrw && $urandom_range(0, 3) == 0) ? $urandom_range(0, wlen) : -1;
      r.ff = $urandom_range(0, 3);
      r.fl = $urandom_range(0, 4);
      r.st = (r.nack_at >= 0) ? 1 : 0;
      apply_row(r);
      last_g = g;
    end

`ifdef I2C_ARB_TIMEOUT_EN
    req_addr = {7'h01, 7'h2B}; req_rw = 2'b00; req_len = {8'd1, 8'd1}; req_valid = 2'b01;
    for (int t = 0; t < 10 && grant == 2'b00; t++) begin
      cyc(); #1;
    end
    req_valid = 2'b00;
    for (int t = 0; t < 400 && done == 2'b00; t++) begin
      cyc(); #1;
    end
    chk("timeout_done", {done, done_status}, {2'b01, 2'b10});
    cyc(); cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
